// File: rtl/pe_operand_feeder.sv
// ---------------------------------------------------------------------------
// nmcu_pkg / pe_operand_feeder
//
// Purpose: feeds a ROWS x COLS systolic PE array. One operand beat (an A
// column of ROWS elements plus a B row of COLS elements) is accepted per
// handshake. Element r of A (c of B) is delayed r+1 (c+1) cycles beyond the
// capture register so that the array sees a diagonal wavefront. A first-beat
// flag rides along with each row of A and drops that row's accumulate enable
// for exactly one cycle, so every job starts from a clean product. After the
// last beat the feeder drains long enough for the wavefront to clear the
// array, then pulses done_o.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i, k_len_i  job request and its beat count (sampled only in IDLE)
//   busy_o, done_o    job in progress / one-cycle completion pulse
//   in_valid_i        operand beat valid
//   in_ready_o        operand beat ready (high only while streaming)
//   a_vec_i, b_vec_i  A column (ROWS elements) and B row (COLS elements)
//   operand_a_o       skewed A stream to the array's first column
//   operand_b_o       skewed B stream to the array's first row
//   accum_en_o        per-row accumulate enable to the array
// ---------------------------------------------------------------------------
package nmcu_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int PE_ROWS    = 4;
  localparam int PE_COLS    = 4;
endpackage

module pe_operand_feeder #(
  parameter int DATA_WIDTH = nmcu_pkg::DATA_WIDTH,
  parameter int ROWS       = nmcu_pkg::PE_ROWS,
  parameter int COLS       = nmcu_pkg::PE_COLS,
  parameter int K_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [K_WIDTH-1:0]    k_len_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] a_vec_i     [ROWS],
  input  logic [DATA_WIDTH-1:0] b_vec_i     [COLS],
  output logic [DATA_WIDTH-1:0] operand_a_o [ROWS],
  output logic [DATA_WIDTH-1:0] operand_b_o [COLS],
  output logic [ROWS-1:0]       accum_en_o
);

  localparam int                 DRAIN_N    = ROWS + COLS + 1;
  localparam int                 DC_W       = $clog2(DRAIN_N + 1);
  localparam logic [DC_W-1:0]    DRAIN_LOAD = DC_W'(DRAIN_N);
  localparam logic [DC_W-1:0]    DC_ONE     = DC_W'(1);
  localparam logic [K_WIDTH-1:0] K_ONE      = K_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_hs;
  logic                 w_first;
  logic                 w_last_beat;
  logic                 w_start_job;
  logic                 w_start_empty;
  logic                 w_drain_end;
  logic [K_WIDTH-1:0]   r_k_len;
  logic [K_WIDTH-1:0]   r_beat_cnt;
  logic [DC_W-1:0]      r_drain_cnt;
  logic                 r_done;

  // Skew chains: stage k of row r is only live for k <= r; higher stages are
  // tied to zero and fall away in synthesis.
  logic [DATA_WIDTH-1:0] r_a_sh [ROWS][ROWS];
  logic                  r_f_sh [ROWS][ROWS];
  logic [DATA_WIDTH-1:0] r_b_sh [COLS][COLS];

  // ---- control: state register -------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // ---- control: next state and handshake decode ---------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_hs          = 1'b0;
    w_last_beat   = 1'b0;
    w_start_job   = 1'b0;
    w_start_empty = 1'b0;
    w_drain_end   = 1'b0;
    in_ready_o    = 1'b0;
    busy_o        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (k_len_i != '0) begin
            w_start_job = 1'b1;
            w_state_nxt = S_STREAM;
          end else begin
            w_start_empty = 1'b1;
          end
        end
      end
      S_STREAM: begin
        in_ready_o  = 1'b1;
        busy_o      = 1'b1;
        w_hs        = in_valid_i;
        // Full-width compare against k_len-1: the counter never needs to
        // reach 2^K_WIDTH, so the maximum k_len cannot wrap.
        w_last_beat = in_valid_i && (r_beat_cnt == (r_k_len - K_ONE));
        if (w_last_beat) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy_o = 1'b1;
        if (r_drain_cnt == DC_ONE) begin
          w_drain_end = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The first beat is identified by the counter rather than by arrival time,
  // so leading bubbles cannot shift the accumulate-clear cycle.
  assign w_first = w_hs && (r_beat_cnt == '0);
  assign done_o  = r_done;

  // ---- control: counters and done pulse -----------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k_len     <= '0;
      r_beat_cnt  <= '0;
      r_drain_cnt <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_start_empty || w_drain_end;
      if (w_start_job) begin
        r_k_len    <= k_len_i;
        r_beat_cnt <= '0;
      end else if (w_hs) begin
        r_beat_cnt <= r_beat_cnt + K_ONE;
      end
      if (w_last_beat)            r_drain_cnt <= DRAIN_LOAD;
      else if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt - DC_ONE;
    end
  end

  // ---- A side: capture, r-stage skew, output register ---------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int k = 0; k < ROWS; k++) begin
          r_a_sh[r][k] <= '0;
          r_f_sh[r][k] <= 1'b0;
        end
        operand_a_o[r] <= '0;
        accum_en_o[r]  <= 1'b0;
      end
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        r_a_sh[r][0] <= w_hs ? a_vec_i[r] : '0;
        r_f_sh[r][0] <= w_first;
        for (int k = 1; k < ROWS; k++) begin
          if (k <= r) begin
            r_a_sh[r][k] <= r_a_sh[r][k-1];
            r_f_sh[r][k] <= r_f_sh[r][k-1];
          end else begin
            r_a_sh[r][k] <= '0;
            r_f_sh[r][k] <= 1'b0;
          end
        end
        operand_a_o[r] <= r_a_sh[r][r];
        accum_en_o[r]  <= ~r_f_sh[r][r];
      end
    end
  end

  // ---- B side: capture, c-stage skew, output register ---------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < COLS; c++) begin
        for (int k = 0; k < COLS; k++) r_b_sh[c][k] <= '0;
        operand_b_o[c] <= '0;
      end
    end else begin
      for (int c = 0; c < COLS; c++) begin
        r_b_sh[c][0] <= w_hs ? b_vec_i[c] : '0;
        for (int k = 1; k < COLS; k++) begin
          if (k <= c) r_b_sh[c][k] <= r_b_sh[c][k-1];
          else        r_b_sh[c][k] <= '0;
        end
        operand_b_o[c] <= r_b_sh[c][c];
      end
    end
  end

endmodule

// File: tb/tb_pe_operand_feeder.sv
// ---------------------------------------------------------------------------
// Testbench for pe_operand_feeder. A job-level reference model at each rising
// edge records, per output cycle, which A/B element and which accumulate-clear
// is due; a monitor on the falling edge pops and compares those entries.
// ---------------------------------------------------------------------------
module tb_pe_operand_feeder;
  localparam int DW  = 16;
  localparam int R   = 4;
  localparam int C   = 4;
  localparam int KW  = 8;
  localparam int NDR = R + C + 1;

  localparam int KIND_RAND = 0;
  localparam int KIND_FIX  = 1;
  localparam int KIND_ID   = 2;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b1;
  logic          start_i    = 1'b0;
  logic [KW-1:0] k_len_i    = '0;
  logic          in_valid_i = 1'b0;
  logic          busy_o, done_o, in_ready_o;
  logic [DW-1:0] a_vec_i [R];
  logic [DW-1:0] b_vec_i [C];
  logic [DW-1:0] operand_a_o [R];
  logic [DW-1:0] operand_b_o [C];
  logic [R-1:0]  accum_en_o;

  pe_operand_feeder #(
    .DATA_WIDTH(DW), .ROWS(R), .COLS(C), .K_WIDTH(KW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .k_len_i(k_len_i),
    .busy_o(busy_o), .done_o(done_o), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .a_vec_i(a_vec_i), .b_vec_i(b_vec_i),
    .operand_a_o(operand_a_o), .operand_b_o(operand_b_o),
    .accum_en_o(accum_en_o)
  );

  always #5 clk = ~clk;

  // ---- reference model -----------------------------------------------------
  typedef enum {M_IDLE, M_STREAM, M_DRAIN} mphase_t;
  mphase_t m_phase = M_IDLE;
  int cyc = 0, last_rst_edge = 0, m_k = 0, m_beats = 0, m_done_at = 0;
  logic [DW-1:0] exp_a [int];
  logic [DW-1:0] exp_b [int];
  bit            low_at [int];
  int            done_q [$];
  int n_cmp = 0, n_err = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      m_phase = M_IDLE;
      exp_a.delete(); exp_b.delete(); low_at.delete(); done_q.delete();
      last_rst_edge = cyc;
    end else begin
      case (m_phase)
        M_IDLE: if (start_i) begin
          if (k_len_i == '0) done_q.push_back(cyc);
          else begin m_phase = M_STREAM; m_k = int'(k_len_i); m_beats = 0; end
        end
        M_STREAM: if (in_valid_i) begin
          for (int r = 0; r < R; r++) begin
            exp_a[(cyc + r + 1) * R + r] = a_vec_i[r];
            if (m_beats == 0) low_at[(cyc + r + 1) * R + r] = 1'b1;
          end
          for (int c = 0; c < C; c++) exp_b[(cyc + c + 1) * C + c] = b_vec_i[c];
          m_beats++;
          if (m_beats == m_k) begin
            m_phase = M_DRAIN; m_done_at = cyc + NDR; done_q.push_back(m_done_at);
          end
        end
        M_DRAIN: if (cyc == m_done_at) m_phase = M_IDLE;
        default: m_phase = M_IDLE;
      endcase
    end
  end

  // ---- monitor / scoreboard ------------------------------------------------
  task automatic chk(input string nm, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] cyc=%0d actual=%0h expected=%0h", nm, idx, cyc, act, exp);
    end
  endtask

  bit            zm, ed;
  int            key;
  logic [DW-1:0] ev;

  always @(negedge clk) begin
    zm = (!rst_n) || (cyc <= last_rst_edge);
    chk("in_ready", 0, 64'(in_ready_o), zm ? 64'd0 : 64'(m_phase == M_STREAM));
    chk("busy",     0, 64'(busy_o),     zm ? 64'd0 : 64'(m_phase != M_IDLE));
    ed = !zm && (done_q.size() > 0) && (done_q[0] == cyc);
    chk("done", 0, 64'(done_o), 64'(ed));
    if (ed) void'(done_q.pop_front());
    for (int r = 0; r < R; r++) begin
      key = cyc * R + r;
      ev  = (!zm && exp_a.exists(key)) ? exp_a[key] : '0;
      chk("operand_a", r, 64'(operand_a_o[r]), 64'(ev));
      chk("accum_en",  r, 64'(accum_en_o[r]), zm ? 64'd0 : 64'(!low_at.exists(key)));
      if (exp_a.exists(key))  exp_a.delete(key);
      if (low_at.exists(key)) low_at.delete(key);
    end
    for (int c = 0; c < C; c++) begin
      key = cyc * C + c;
      ev  = (!zm && exp_b.exists(key)) ? exp_b[key] : '0;
      chk("operand_b", c, 64'(operand_b_o[c]), 64'(ev));
      if (exp_b.exists(key)) exp_b.delete(key);
    end
  end

  // ---- stimulus ------------------------------------------------------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_bus(input int kind, input int i);
    for (int r = 0; r < R; r++)
      case (kind)
        KIND_FIX: a_vec_i[r] = DW'(r + 1);
        KIND_ID:  a_vec_i[r] = (r == i) ? DW'(1) : DW'(0);
        default:  a_vec_i[r] = DW'($urandom);
      endcase
    for (int c = 0; c < C; c++)
      case (kind)
        KIND_FIX: b_vec_i[c] = DW'(c + 5);
        KIND_ID:  b_vec_i[c] = DW'(i * C + c + 1);
        default:  b_vec_i[c] = DW'($urandom);
      endcase
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && m_phase != M_IDLE; i++) begin
      in_valid_i = 1'($urandom_range(1)); set_bus(KIND_RAND, 0); tick();
    end
    in_valid_i = 1'b0;
    if (m_phase != M_IDLE) begin
      n_err++;
      $display("FAIL wait_idle cyc=%0d actual=busy required=idle", cyc);
    end
  endtask

  // gap_after: beat index followed by exactly two bubbles (-1 for none)
  task automatic run_job(input int k, input int kind, input int bub_pct,
                         input int gap_after, input bit start_mid, input bit rst_drain);
    start_i = 1'b1; k_len_i = KW'(k); tick(); start_i = 1'b0;
    if (k == 0) begin repeat (2) tick(); return; end
    for (int i = 0; i < k; i++) begin
      for (int b = 0; b < 3 && $urandom_range(99) < bub_pct; b++) begin
        in_valid_i = 1'b0; set_bus(KIND_RAND, 0); tick();
      end
      in_valid_i = 1'b1; set_bus(kind, i);
      if (start_mid && i == 1) begin start_i = 1'b1; k_len_i = KW'(k + 3); end
      tick();
      start_i = 1'b0;
      if (i == gap_after) begin
        in_valid_i = 1'b0; set_bus(KIND_RAND, 0); tick(); tick();
      end
    end
    in_valid_i = 1'b0;
    if (start_mid) begin start_i = 1'b1; k_len_i = KW'(1); tick(); start_i = 1'b0; end
    if (rst_drain) begin
      repeat (2) tick();
      rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    end else begin
      wait_idle();
    end
  endtask

  initial begin
    set_bus(KIND_RAND, 0);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    run_job(1,  KIND_FIX,  0, -1, 1'b0, 1'b0);
    run_job(4,  KIND_ID,   0,  0, 1'b0, 1'b0);
    run_job(0,  KIND_RAND, 0, -1, 1'b0, 1'b0);
    run_job(3,  KIND_RAND, 0, -1, 1'b0, 1'b0);
    run_job(3,  KIND_RAND, 0, -1, 1'b0, 1'b0);
    run_job(5,  KIND_RAND, 20, -1, 1'b1, 1'b0);
    run_job(5,  KIND_RAND, 0, -1, 1'b0, 1'b1);
    run_job(2,  KIND_RAND, 0, -1, 1'b0, 1'b0);
    run_job(255, KIND_RAND, 10, -1, 1'b0, 1'b0);
    for (int j = 0; j < 30; j++) begin
      repeat ($urandom_range(3)) tick();
      run_job($urandom_range(9), KIND_RAND, $urandom_range(40), -1,
              1'($urandom_range(1)), ($urandom_range(9) == 0));
    end
    repeat (20) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pe_operand_feeder.md
PE_OPERAND_FEEDER -- requirements
Module: pe_operand_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default nmcu_pkg::DATA_WIDTH, operand width.
REQ-002 SHALL have parameter ROWS, default nmcu_pkg::PE_ROWS, array rows.
REQ-003 SHALL have parameter COLS, default nmcu_pkg::PE_COLS, array columns.
REQ-004 SHALL have parameter K_WIDTH, default 8, width of the beat-count field.
REQ-005 clk  input  1  single clock; all state on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start_i  input  1  job start request, sampled only in IDLE.
REQ-008 k_len_i  input  K_WIDTH  number of K beats in the job, latched on accepted start.
REQ-009 busy_o  output  1  high in STREAM and DRAIN.
REQ-010 done_o  output  1  one-cycle pulse: all PE results final.
REQ-011 in_valid_i  input  1  operand beat valid.
REQ-012 in_ready_o  output  1  feeder accepts a beat.
REQ-013 a_vec_i  input  DATA_WIDTH x ROWS  unpacked; A column for this K step, one element per row.
REQ-014 b_vec_i  input  DATA_WIDTH x COLS  unpacked; B row for this K step, one element per column.
REQ-015 operand_a_o  output  DATA_WIDTH x ROWS  skewed stream to array first column.
REQ-016 operand_b_o  output  DATA_WIDTH x COLS  skewed stream to array first row.
REQ-017 accum_en_o  output  ROWS  per-row accumulate enable to array.

Function
REQ-018 FSM states SHALL be IDLE, STREAM, DRAIN; handshake = in_valid_i && in_ready_o.
REQ-019 IDLE: start_i with k_len_i!=0 -> STREAM, latch k_len, clear beat counter; start_i with k_len_i==0 -> stay IDLE, done_o pulses next cycle.
REQ-020 start_i SHALL be ignored in STREAM and DRAIN.
REQ-021 in_ready_o SHALL be 1 only in STREAM; never depends combinationally on in_valid_i.
REQ-022 STREAM: each handshake increments beat counter; handshake on beat k_len-1 -> DRAIN, drain counter loaded with ROWS+COLS+1.
REQ-023 DRAIN: counter decrements each cycle; transition to IDLE and done_o=1 in the cycle after the counter reaches 1, i.e. done_o high in the cycle following edge t+ROWS+COLS+1, t = acceptance edge of last beat.
REQ-024 Skew: a_vec_i[r] accepted at edge t SHALL appear on operand_a_o[r] after edge t+r+1; b_vec_i[c] on operand_b_o[c] after edge t+c+1; outputs registered.
REQ-025 Cycles without handshake (bubbles, IDLE, DRAIN) SHALL inject zero into every skew chain.
REQ-026 A first-beat flag SHALL travel with each row's a element through the same r+1 delay.
REQ-027 accum_en_o[r] SHALL be 0 exactly in the cycle operand_a_o[r] carries the job's first beat, and 1 in all other cycles after that, including IDLE after done, so array results are held.
REQ-028 Bubbles before the first beat SHALL NOT move the accum_en_o low cycle; it tracks the first accepted beat.
REQ-029 No arithmetic on data; elements pass bit-exact; beat counter compares at full K_WIDTH, no wrap for k_len=2^K_WIDTH-1.

Reset
REQ-030 On rst_n low, immediately: state IDLE, counters 0, all skew chains 0, operand_a_o/operand_b_o 0, accum_en_o all 0, busy_o 0, done_o 0, in_ready_o 0.
REQ-031 Reset mid-STREAM or mid-DRAIN SHALL abandon the job with no done_o pulse; first start after release starts a fresh job.

Verification
REQ-032 4x4, k_len=1, a=(1,2,3,4), b=(5,6,7,8), no bubbles -> operand_a_o[3]=4 and accum_en_o[3]=0 after edge t+4; done_o after edge t+9; array result[i][j]=a[i]*b[j].
REQ-033 4x4, k_len=4, identity A x sequential B with in_valid low 2 cycles between beats 1 and 2 -> results equal A*B, done_o edge = last-acceptance edge +9, in_ready_o high throughout STREAM.
REQ-034 start_i with k_len_i=0 -> done_o one cycle, busy_o never high, accum_en_o unchanged.
REQ-035 Back-to-back jobs, second start one cycle after done_o -> second job's accum_en_o low cycle per row clears prior results; first job results stable until then.
REQ-036 rst_n asserted two cycles into DRAIN -> all outputs 0 same cycle, no done_o; next job k_len=2 completes correctly.
REQ-037 start_i pulsed during STREAM with different k_len_i -> ignored; beat count uses original k_len.
